// File: rtl/led_display_ctrl_if.sv
// LED display bus: game-side mode/pattern inputs and the registered LED drive.
interface led_display_ctrl_if #(
  parameter int unsigned N = 7
);
  logic         tick;
  logic [2:0]   led_control;
  logic [N-1:0] score;
  logic [N-1:0] fake_score;
  logic [N-1:0] speed_led;
  logic [N-1:0] leds_out;
  logic         blink_phase;

  modport master (
    output tick, led_control, score, fake_score, speed_led,
    input  leds_out, blink_phase
  );

  modport slave (
    input  tick, led_control, score, fake_score, speed_led,
    output leds_out, blink_phase
  );
endinterface

// File: rtl/led_display_ctrl.sv
// LED bar selector: static patterns, live/fake/speed scores, blinking score
// and a ping-pong chase, with the LED pins driven straight from a register.
module led_display_ctrl #(
  parameter int unsigned N          = 7,
  parameter logic [31:0] RESET_CODE = 32'b1001000,
  parameter int unsigned BLINK_HALF = 250,
  parameter int unsigned CHASE_STEP = 50
) (
  input  logic                clk,
  input  logic                rst,
  led_display_ctrl_if.slave   disp
);

  localparam int unsigned CMAX = (BLINK_HALF > CHASE_STEP) ? BLINK_HALF : CHASE_STEP;
  localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int unsigned PW   = (N > 1) ? $clog2(N) : 1;

  localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_HALF - 1);
  localparam logic [CW-1:0] CHASE_LAST = CW'(CHASE_STEP - 1);
  localparam logic [PW-1:0] POS_LAST   = PW'(N - 1);
  localparam logic [PW-1:0] POS_PEN    = PW'((N > 1) ? (N - 2) : 0);
  localparam logic [PW-1:0] POS_ONE    = PW'((N > 1) ? 1 : 0);

  typedef enum logic [2:0] {
    MODE_DARK  = 3'b000,
    MODE_RESET = 3'b001,
    MODE_ALL   = 3'b010,
    MODE_SCORE = 3'b011,
    MODE_FAKE  = 3'b100,
    MODE_BLINK = 3'b101,
    MODE_SPEED = 3'b110,
    MODE_CHASE = 3'b111
  } mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  mode_t         ctrl_q, ctrl_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;
  logic [PW-1:0] pos_q, pos_d;
  dir_t          dir_q, dir_d;
  logic [N-1:0]  leds_q, leds_d;

  // Next animation state: a mode change restarts timing and drops any same-edge tick.
  always_comb begin
    ctrl_d  = mode_t'(disp.led_control);
    cnt_d   = cnt_q;
    phase_d = phase_q;
    pos_d   = pos_q;
    dir_d   = dir_q;
    if (ctrl_d != ctrl_q) begin
      cnt_d   = '0;
      phase_d = 1'b1;
      pos_d   = '0;
      dir_d   = DIR_UP;
    end else if (disp.tick) begin
      if (ctrl_q == MODE_BLINK) begin
        if (cnt_q == BLINK_LAST) begin
          cnt_d   = '0;
          phase_d = ~phase_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end else if (ctrl_q == MODE_CHASE) begin
        if (cnt_q == CHASE_LAST) begin
          cnt_d = '0;
          if (N > 1) begin
            if (dir_q == DIR_UP) begin
              if (pos_q == POS_LAST) begin
                dir_d = DIR_DOWN;
                pos_d = POS_PEN;
              end else begin
                pos_d = pos_q + PW'(1);
              end
            end else begin
              if (pos_q == '0) begin
                dir_d = DIR_UP;
                pos_d = POS_ONE;
              end else begin
                pos_d = pos_q - PW'(1);
              end
            end
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end
  end

  // LED frame decoded from the current mode and the post-update animation state.
  always_comb begin
    leds_d = '0;
    unique case (ctrl_d)
      MODE_DARK:  leds_d = '0;
      MODE_RESET: leds_d = RESET_CODE[N-1:0];
      MODE_ALL:   leds_d = '1;
      MODE_SCORE: leds_d = disp.score;
      MODE_FAKE:  leds_d = disp.fake_score;
      MODE_BLINK: leds_d = phase_d ? disp.score : '0;
      MODE_SPEED: leds_d = disp.speed_led;
      MODE_CHASE: leds_d[pos_d] = 1'b1;
    endcase
  end

  // State and LED register; reset clears the bar immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q  <= MODE_DARK;
      cnt_q   <= '0;
      phase_q <= 1'b1;
      pos_q   <= '0;
      dir_q   <= DIR_UP;
      leds_q  <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      leds_q  <= leds_d;
    end
  end

  assign disp.leds_out    = leds_q;
  assign disp.blink_phase = phase_q;

endmodule

// File: tb/tb_led_display_ctrl.sv
// Directed bench for led_display_ctrl with N=7, BLINK_HALF=4, CHASE_STEP=2.
module tb_led_display_ctrl;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  led_display_ctrl_if #(.N(7)) disp ();

  led_display_ctrl #(
    .N          (7),
    .RESET_CODE (32'b1001000),
    .BLINK_HALF (4),
    .CHASE_STEP (2)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .disp (disp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=%b exp=%b", tag, got, exp);
    else n_pass++;
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int seq [12] = '{0, 1, 2, 3, 4, 5, 6, 5, 4, 3, 2, 1};
    n_checks = 0;
    n_pass   = 0;

    // Reset with chase code applied
    rst              = 1'b1;
    disp.tick        = 1'b0;
    disp.led_control = 3'b111;
    disp.score       = 7'b0010100;
    disp.fake_score  = 7'b1100000;
    disp.speed_led   = 7'b0000111;
    #2;
    check("rst_async", 32'(disp.leds_out), 32'b0);
    step();
    check("rst_hold", 32'(disp.leds_out), 32'b0);
    check("rst_phase", 32'(disp.blink_phase), 32'd1);

    // Static modes
    rst = 1'b0; disp.led_control = 3'b000; step();
    check("dark", 32'(disp.leds_out), 32'b0000000);
    disp.led_control = 3'b001; step();
    check("reset_code", 32'(disp.leds_out), 32'b1001000);
    disp.led_control = 3'b010; step();
    check("all_on", 32'(disp.leds_out), 32'b1111111);
    disp.led_control = 3'b011; step();
    check("score", 32'(disp.leds_out), 32'b0010100);
    disp.led_control = 3'b100; step();
    check("fake", 32'(disp.leds_out), 32'b1100000);
    disp.led_control = 3'b110; step();
    check("speed", 32'(disp.leds_out), 32'b0000111);

    // Blink: tick every 3rd cycle, toggle every 4 ticks
    disp.score = 7'b0011100;
    disp.led_control = 3'b101; step();
    check("blink_enter", 32'(disp.leds_out), 32'b0011100);
    check("blink_enter_ph", 32'(disp.blink_phase), 32'd1);
    for (int k = 1; k <= 12; k++) begin
      logic ph;
      ph = ((k / 4) % 2) == 0;
      disp.tick = 1'b1; step();
      disp.tick = 1'b0;
      check($sformatf("blink_t%0d", k), 32'(disp.leds_out), ph ? 32'b0011100 : 32'b0);
      check($sformatf("blink_ph%0d", k), 32'(disp.blink_phase), 32'(ph));
      step(); step();
      check($sformatf("blink_hold%0d", k), 32'(disp.leds_out), ph ? 32'b0011100 : 32'b0);
    end

    // Two more ticks: phase 0, cnt 2
    disp.tick = 1'b1; step(); step();
    disp.tick = 1'b0;
    check("blink_mid_ph", 32'(disp.blink_phase), 32'd0);
    check("blink_mid_led", 32'(disp.leds_out), 32'b0);

    // Restart on change
    disp.led_control = 3'b011; step();
    check("restart_score", 32'(disp.leds_out), 32'b0011100);
    disp.led_control = 3'b101; step();
    check("restart_blink", 32'(disp.leds_out), 32'b0011100);
    check("restart_ph", 32'(disp.blink_phase), 32'd1);
    disp.tick = 1'b1; step(); step(); step();
    check("restart_t3", 32'(disp.leds_out), 32'b0011100);
    step();
    disp.tick = 1'b0;
    check("restart_t4", 32'(disp.leds_out), 32'b0);
    check("restart_t4_ph", 32'(disp.blink_phase), 32'd0);

    // Simultaneous change and tick, then continuous chase
    disp.led_control = 3'b011; step();
    disp.led_control = 3'b111; disp.tick = 1'b1; step();
    check("chase_enter", 32'(disp.leds_out), 32'b0000001);
    for (int t = 1; t <= 32; t++) begin
      step();
      check($sformatf("chase_t%0d", t), 32'(disp.leds_out), 32'(1) << seq[(t / 2) % 12]);
    end

    // Async reset mid-chase at pos 4
    disp.tick = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    check("rst_mid_chase", 32'(disp.leds_out), 32'b0);
    step();
    rst = 1'b0;
    step();
    check("chase_restart", 32'(disp.leds_out), 32'b0000001);
    disp.tick = 1'b1; step();
    check("chase_restart_t1", 32'(disp.leds_out), 32'b0000001);
    step();
    check("chase_restart_t2", 32'(disp.leds_out), 32'b0000010);
    disp.tick = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/led_display_ctrl.md
# led_display_ctrl

Registered, parametrised successor to the tug-of-war LED selector. It selects what the N-LED bar shows: dark, reset code, all-on, live score, fake-round score, or speed indication. It adds two timed modes: a blinking score and a ping-pong chase animation, both paced by the game's tick strobe. It sits between the game FSM/scorer and the board LED pins, and it drives the pins directly from a register.

## Interface
- `N` — default 7 — number of LEDs; legal range 1..32.
- `RESET_CODE` — default 7'b1001000 (zero-extended to N) — pattern shown in reset-code mode.
- `BLINK_HALF` — default 250 — ticks per blink half-period; minimum 1.
- `CHASE_STEP` — default 50 — ticks per chase position step; minimum 1.
- `clk` — in — 1 — system clock.
- `rst` — in — 1 — reset, asynchronous, active-high.
- `tick` — in — 1 — one-cycle timing strobe from the game timebase; only counted when high on a clk edge.
- `led_control` — in — 3 — mode select from the game FSM.
- `score` — in — N — scorer LED pattern.
- `fake_score` — in — N — fake-round LED pattern.
- `speed_led` — in — N — speed-indicator pattern.
- `leds_out` — out — N — registered LED drive; bit 0 is the leftmost LED.
- `blink_phase` — out — 1 — current blink phase (1 = on), for test and debug.

## Operation
- Mode decode (led_control):
  - 000 = all zeros (dark).
  - 001 = RESET_CODE.
  - 010 = all ones (wait states).
  - 011 = score.
  - 100 = fake_score.
  - 101 = blink score: score when blink_phase=1, zeros when 0.
  - 110 = speed_led.
  - 111 = chase: one-hot, bit pos set.
- Internal state:
  - ctrl_q (3 b): last sampled led_control.
  - cnt: width clog2(max(BLINK_HALF,CHASE_STEP)).
  - blink_phase.
  - pos: 0..N-1.
  - dir: up/down.
- Mode change (led_control != ctrl_q): ctrl_q<=led_control, cnt<=0, blink_phase<=1, pos<=0, dir<=up. This takes priority over a tick on the same edge; that tick is discarded.
- No change, tick=1:
  - Mode 101: if cnt==BLINK_HALF-1, cnt<=0 and blink_phase toggles; else cnt+1.
  - Mode 111: if cnt==CHASE_STEP-1, cnt<=0 and pos steps in dir; else cnt+1.
  - Other modes: cnt, blink_phase and pos hold.
- Chase direction:
  - Moving up and pos==N-1: dir<=down and pos<=N-2.
  - Moving down and pos==0: dir<=up and pos<=1.
  - Each end position is therefore shown once per pass; the period is 2(N-1) steps.
  - N=1: pos stays 0 and leds_out=1.
- No change, tick=0: all state holds.
- Changes on score, fake_score or speed_led never restart the blink or chase timing; they show up on the next edge.
- Mode codes are exhaustive: there is no default/unused code.

## Timing
- leds_out is a register loaded every edge from the decode of the current led_control, using the post-update state of that same edge. Latency is 1 clk from any input change.
- On the edge that detects a mode change, leds_out takes the new mode's first frame: blink shows score (phase 1); chase shows bit 0.
- Blink toggle edge: the edge that accepts the BLINK_HALF-th tick both toggles blink_phase and updates leds_out.
- Chase step: the same rule applies to the CHASE_STEP-th tick.
- Reset (async assert, sync release by board convention):
  - leds_out=0, ctrl_q=000, cnt=0, blink_phase=1, pos=0, dir=up.
  - Mid-animation reset clears immediately with no completion of the current step.
- First edge after reset: led_control=000 gives no change-event; any other code is treated as a mode change.

## Test plan
- Reset and static modes:
  - Stimulus: assert rst with led_control=111, then release and apply codes 000, 001, 010, 011 (score=0010100), 100 (fake=1100000), 110 (speed=0000111).
  - Required: leds_out=0000000 during reset; then 0000000, 1001000, 1111111, 0010100, 1100000, 0000111, each 1 clk after the code is applied.
- Blink (BLINK_HALF=4, score=0011100):
  - Stimulus: enter 101, then pulse tick every 3rd cycle.
  - Required: leds_out=0011100 for 4 ticks, 0000000 for 4 ticks, repeating; blink_phase tracks the same pattern.
- Chase (N=7, CHASE_STEP=2):
  - Stimulus: enter 111 with continuous tick.
  - Required: pos sequence 0,1,2,3,4,5,6,5,4,3,2,1,0,1… with each position held for 2 ticks; leds_out=1<<pos.
- Restart on change:
  - Stimulus: in blink at phase 0 with cnt=2, switch to 011 then back to 101.
  - Required: score shows immediately (phase 1) and a full 4 ticks elapse before the next toggle.
- Simultaneous change and tick:
  - Stimulus: tick=1 on the same edge that led_control goes 011→111.
  - Required: cnt=0, pos=0, leds_out=0000001; the first step happens 2 ticks later.
- Async reset mid-chase:
  - Stimulus: assert rst between clk edges while pos=4.
  - Required: leds_out=0 immediately without waiting for clk; after release with led_control=111, chase restarts at pos 0.
